// File: rtl/risc_pkg.sv
// Shared Risc16 definitions: instruction width, the loader frame start byte
// and the loader state encoding.
package risc_pkg;
    localparam int         INSTR_W   = 16;
    localparam logic [7:0] MAGIC_DEF = 8'hA5;

    typedef enum logic [2:0] {
        WAIT_MAGIC,
        GET_COUNT,
        GET_LO,
        GET_HI,
        GET_SUM,
        DONE,
        ERROR
    } ld_state_e;
endpackage

// File: rtl/risc_prog_loader_if.sv
// Byte stream into the program loader. The source drives data and valid.
// The loader drives ready.
interface risc_prog_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, in_valid, input in_ready);
    modport slave  (input in_data, in_valid, output in_ready);
endinterface

// File: rtl/gap_timer.sv
// Idle-gap counter. It clears on every accepted byte and holds at zero while
// disabled. It asserts expire combinationally once it reaches TIMEOUT_CYC-1.
module gap_timer #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CW-1:0] cnt;

    assign expire = en && (cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset || clr || !en)
            cnt <= '0;
        else if (!expire)
            cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/risc_prog_loader.sv
// Fills the Risc16 instruction memory from a framed byte stream:
// MAGIC, COUNT, COUNT x (LO, HI), then SUM, where SUM is the XOR of the data bytes.
module risc_prog_loader
    import risc_pkg::*;
#(
    parameter int         ADDR_W      = 4,
    parameter logic [7:0] MAGIC       = MAGIC_DEF,
    parameter int         TIMEOUT_CYC = 1000000
) (
    input  logic                clk,
    input  logic                reset,
    risc_prog_loader_if.slave   in_bus,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [INSTR_W-1:0]  mem_wdata,
    output logic                cpu_hold,
    output logic                load_done,
    output logic                load_error,
    output logic [ADDR_W:0]     words_loaded
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CW    = ADDR_W + 1;

    ld_state_e           state, state_n;
    logic [CW-1:0]       count_q, count_n, wl_n;
    logic [7:0]          lo_q, lo_n, sum_q, sum_n;
    logic                we_n;
    logic [ADDR_W-1:0]   addr_n;
    logic [INSTR_W-1:0]  wdata_n;
    logic                acc, gap_en, expire;

    assign in_bus.in_ready = 1'b1;
    assign acc    = in_bus.in_valid && in_bus.in_ready;
    assign gap_en = state inside {GET_COUNT, GET_LO, GET_HI, GET_SUM};

    gap_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_gap (
        .clk    (clk),
        .reset  (reset),
        .clr    (acc),
        .en     (gap_en),
        .expire (expire)
    );

    always_comb begin
        state_n = state;
        count_n = count_q;
        lo_n    = lo_q;
        sum_n   = sum_q;
        we_n    = 1'b0;
        addr_n  = mem_addr;
        wdata_n = mem_wdata;
        wl_n    = words_loaded;
        if (acc) begin
            case (state)
                WAIT_MAGIC, DONE, ERROR: begin
                    if (in_bus.in_data == MAGIC) begin
                        state_n = GET_COUNT;
                        sum_n   = 8'h00;
                        wl_n    = '0;
                    end
                end
                GET_COUNT: begin
                    if (in_bus.in_data == 8'h00 || int'(in_bus.in_data) > DEPTH)
                        state_n = ERROR;
                    else begin
                        count_n = CW'(in_bus.in_data);
                        state_n = GET_LO;
                    end
                end
                GET_LO: begin
                    lo_n    = in_bus.in_data;
                    sum_n   = sum_q ^ in_bus.in_data;
                    state_n = GET_HI;
                end
                GET_HI: begin
                    // The word index is the low bits of words_loaded. With a full-depth
                    // frame it wraps to 0 after the final write.
                    we_n    = 1'b1;
                    addr_n  = words_loaded[ADDR_W-1:0];
                    wdata_n = {in_bus.in_data, lo_q};
                    sum_n   = sum_q ^ in_bus.in_data;
                    wl_n    = words_loaded + CW'(1);
                    state_n = (wl_n == count_q) ? GET_SUM : GET_LO;
                end
                GET_SUM: state_n = (in_bus.in_data == sum_q) ? DONE : ERROR;
                default: state_n = WAIT_MAGIC;
            endcase
        end else if (expire) begin
            state_n = ERROR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= WAIT_MAGIC;
            count_q      <= '0;
            lo_q         <= 8'h00;
            sum_q        <= 8'h00;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            words_loaded <= '0;
            cpu_hold     <= 1'b1;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
        end else begin
            state        <= state_n;
            count_q      <= count_n;
            lo_q         <= lo_n;
            sum_q        <= sum_n;
            mem_we       <= we_n;
            mem_addr     <= addr_n;
            mem_wdata    <= wdata_n;
            words_loaded <= wl_n;
            // The flags and the hold are registered from the next state, so they
            // change together.
            cpu_hold     <= (state_n != DONE);
            load_done    <= (state_n == DONE);
            load_error   <= (state_n == ERROR);
        end
    end
endmodule

// File: tb/tb_risc_prog_loader.sv
// Directed bench for risc_prog_loader. It applies a per-byte vector table,
// then runs hand-written timeout, mid-frame reset and full-depth wrap sequences.
module tb_risc_prog_loader;
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_hold, load_done, load_error;
    logic [4:0]  words_loaded;

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;

    always #5 clk = ~clk;

    risc_prog_loader_if bus ();

    risc_prog_loader #(.ADDR_W(4), .MAGIC(8'hA5), .TIMEOUT_CYC(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_bus       (bus),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always @(negedge clk) if (mem_we === 1'b1) wr_cnt++;

    typedef struct packed {
        logic        rdy;
        logic        we;
        logic [3:0]  addr;
        logic [15:0] wdata;
        logic        hold;
        logic        done;
        logic        err;
        logic [4:0]  wl;
    } outs_t;

    typedef struct {
        logic       vld;
        logic [7:0] data;
        outs_t      exp;
    } vec_t;

    vec_t tv[$];

    function automatic outs_t o(logic we, logic [3:0] a, logic [15:0] d,
                                logic h, logic dn, logic er, logic [4:0] wl);
        return '{1'b1, we, a, d, h, dn, er, wl};
    endfunction

    function automatic outs_t act();
        return {bus.in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_error, words_loaded};
    endfunction

    task automatic add(input logic v, input logic [7:0] d, input outs_t e);
        vec_t x;
        x.vld = v; x.data = d; x.exp = e;
        tv.push_back(x);
    endtask

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    // Drive one cycle of stream input. Return on the next falling edge, after the byte has been taken.
    task automatic step(input logic v, input logic [7:0] d);
        bus.in_valid = v;
        bus.in_data  = d;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] lo, hi, s;
        int w0;
        outs_t idle_o;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle_o = o(0, 0, 16'h0000, 1, 0, 0, 0);
        chk("reset_vals", act(), idle_o);

        // Good 3-word frame. The checksum is 34^12^78^56^BC^9A = 2E.
        add(1, 8'hA5, o(0, 0, 16'h0000, 1, 0, 0, 0));
        add(1, 8'h03, o(0, 0, 16'h0000, 1, 0, 0, 0));
        add(1, 8'h34, o(0, 0, 16'h0000, 1, 0, 0, 0));
        add(1, 8'h12, o(1, 0, 16'h1234, 1, 0, 0, 1));
        add(1, 8'h78, o(0, 0, 16'h1234, 1, 0, 0, 1));
        add(1, 8'h56, o(1, 1, 16'h5678, 1, 0, 0, 2));
        add(1, 8'hBC, o(0, 1, 16'h5678, 1, 0, 0, 2));
        add(1, 8'h9A, o(1, 2, 16'h9ABC, 1, 0, 0, 3));
        add(1, 8'h2E, o(0, 2, 16'h9ABC, 0, 1, 0, 3));
        add(0, 8'h00, o(0, 2, 16'h9ABC, 0, 1, 0, 3));
        // Noise in DONE is ignored. A MAGIC byte then starts a 1-word reload.
        add(1, 8'h00, o(0, 2, 16'h9ABC, 0, 1, 0, 3));
        add(1, 8'hFF, o(0, 2, 16'h9ABC, 0, 1, 0, 3));
        add(1, 8'hA5, o(0, 2, 16'h9ABC, 1, 0, 0, 0));
        add(1, 8'h01, o(0, 2, 16'h9ABC, 1, 0, 0, 0));
        add(1, 8'h11, o(0, 2, 16'h9ABC, 1, 0, 0, 0));
        add(1, 8'h22, o(1, 0, 16'h2211, 1, 0, 0, 1));
        add(1, 8'h33, o(0, 0, 16'h2211, 0, 1, 0, 1));
        // Bad checksum: the writes still happen, then the frame ends in ERROR.
        add(1, 8'hA5, o(0, 0, 16'h2211, 1, 0, 0, 0));
        add(1, 8'h03, o(0, 0, 16'h2211, 1, 0, 0, 0));
        add(1, 8'h34, o(0, 0, 16'h2211, 1, 0, 0, 0));
        add(1, 8'h12, o(1, 0, 16'h1234, 1, 0, 0, 1));
        add(1, 8'h78, o(0, 0, 16'h1234, 1, 0, 0, 1));
        add(1, 8'h56, o(1, 1, 16'h5678, 1, 0, 0, 2));
        add(1, 8'hBC, o(0, 1, 16'h5678, 1, 0, 0, 2));
        add(1, 8'h9A, o(1, 2, 16'h9ABC, 1, 0, 0, 3));
        add(1, 8'h00, o(0, 2, 16'h9ABC, 1, 0, 1, 3));
        add(0, 8'h00, o(0, 2, 16'h9ABC, 1, 0, 1, 3));
        // Illegal counts 0 and 17.
        add(1, 8'hA5, o(0, 2, 16'h9ABC, 1, 0, 0, 0));
        add(1, 8'h00, o(0, 2, 16'h9ABC, 1, 0, 1, 0));
        add(1, 8'hA5, o(0, 2, 16'h9ABC, 1, 0, 0, 0));
        add(1, 8'h11, o(0, 2, 16'h9ABC, 1, 0, 1, 0));

        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].vld, tv[i].data);
            chk($sformatf("vec%0d", i), act(), tv[i].exp);
        end

        // Timeout: after the LO byte, 15 idle cycles are not enough and the 16th aborts.
        step(1, 8'hA5);
        step(1, 8'h02);
        step(1, 8'h34);
        for (int i = 0; i < 15; i++) step(0, 8'h00);
        chk("timeout_early", {cpu_hold, load_error}, 2'b10);
        step(0, 8'h00);
        chk("timeout_fire", {cpu_hold, load_done, load_error}, 3'b101);
        step(1, 8'hA5);
        step(1, 8'h01);
        step(1, 8'hCD);
        step(1, 8'hAB);
        chk("after_to_write", act(), o(1, 0, 16'hABCD, 1, 0, 0, 1));
        step(1, 8'h66);
        chk("after_to_done", act(), o(0, 0, 16'hABCD, 0, 1, 0, 1));

        // Reset mid-frame, after the LO byte of word 1.
        step(1, 8'hA5);
        step(1, 8'h02);
        step(1, 8'h34);
        step(1, 8'h12);
        step(1, 8'h56);
        reset = 1'b1;
        step(0, 8'h00);
        reset = 1'b0;
        chk("midreset_vals", act(), idle_o);
        w0 = wr_cnt;
        step(1, 8'h78);
        chk("stray_hi_drop", act(), idle_o);

        // Full 16-word frame. The word index wraps without a 17th write.
        s = 8'h00;
        step(1, 8'hA5);
        step(1, 8'h10);
        for (int i = 0; i < 16; i++) begin
            lo = 8'(i * 3);
            hi = 8'hC0 | 8'(i);
            s  = s ^ lo ^ hi;
            step(1, lo);
            step(1, hi);
            chk($sformatf("wr%0d", i), {mem_we, mem_addr, mem_wdata}, {1'b1, 4'(i), hi, lo});
        end
        step(1, s);
        chk("full_done", act(), o(0, 15, {8'hCF, 8'd45}, 0, 1, 0, 16));
        for (int i = 0; i < 3; i++) step(0, 8'h00);
        chk("full_writes", 32'(wr_cnt - w0), 32'd16);
        chk("full_no_wrap_we", {mem_we, load_done, words_loaded}, {1'b0, 1'b1, 5'd16});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
